alu32_reg: RTL and testbench

- 32-bit integer ALU with a 4-bit opcode and one registered result stage.
- Functions: AND/OR/XOR/NOR, add, subtract, signed compare, logical shift left.
- Produces result F plus five status flags: ZF, CF, OF, SF, PF.
- Sits in the datapath execute stage; the flags feed branch/condition logic.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_adder.sv | 25 ++
 rtl/alu32_reg.sv | 104 ++++++++++
 tb/tb_alu32_reg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes and width default for the alu32_reg execute-stage ALU
package alu_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_SUB = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_SAL = 4'd7;

endpackage

// File: rtl/alu_adder.sv
// rtl/alu_adder.sv - shared add/subtract unit with carry-or-borrow and signed overflow
module alu_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cf,
    output logic             o_of
);

    logic [WIDTH:0]   w_full;
    logic [WIDTH-1:0] w_b_eff;

    // Subtraction is A + ~B + 1; the raw carry out is then the inverse of borrow.
    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};
    assign o_sum   = w_full[WIDTH-1:0];
    assign o_cf    = w_full[WIDTH] ^ i_sub;
    assign o_of    = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/alu32_reg.sv
// rtl/alu32_reg.sv - 32-bit ALU with one registered result stage and ZF/CF/OF/SF/PF flags
module alu32_reg
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OP,
    output logic [WIDTH-1:0] F,
    output logic             ZF,
    output logic             CF,
    output logic             OF,
    output logic             SF,
    output logic             PF
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    logic [WIDTH-1:0]   w_sum;
    logic               w_add_cf;
    logic               w_add_of;
    logic [2*WIDTH-1:0] w_wide;
    logic               w_big_shift;
    logic [WIDTH-1:0]   w_f;
    logic               w_cf;
    logic               w_of;

    logic [WIDTH-1:0]   r_f;
    logic               r_zf, r_cf, r_of, r_sf, r_pf;

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a   (A),
        .i_b   (B),
        .i_sub (OP != OP_ADD),
        .o_sum (w_sum),
        .o_cf  (w_add_cf),
        .o_of  (w_add_of)
    );

    // The upper half of the double-width shift holds exactly the bits pushed out of B.
    assign w_wide      = {{WIDTH{1'b0}}, B} << A[SHW-1:0];
    assign w_big_shift = (A >= SHIFT_LIMIT);

    always_comb begin
        w_f  = '0;
        w_cf = 1'b0;
        w_of = 1'b0;
        case (OP)
            OP_AND: w_f = A & B;
            OP_OR:  w_f = A | B;
            OP_XOR: w_f = A ^ B;
            OP_NOR: w_f = ~(A | B);
            OP_ADD, OP_SUB: begin
                w_f  = w_sum;
                w_cf = w_add_cf;
                w_of = w_add_of;
            end
            OP_CMP: begin
                w_f  = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_of};
                w_cf = w_add_cf;
                w_of = w_add_of;
            end
            OP_SAL: begin
                if (w_big_shift) begin
                    w_of = |B;
                end else begin
                    w_f  = w_wide[WIDTH-1:0];
                    w_of = |w_wide[2*WIDTH-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f  <= '0;
            r_zf <= 1'b0;
            r_cf <= 1'b0;
            r_of <= 1'b0;
            r_sf <= 1'b0;
            r_pf <= 1'b0;
        end else begin
            r_f  <= w_f;
            r_zf <= (w_f == '0);
            r_cf <= w_cf;
            r_of <= w_of;
            r_sf <= w_f[WIDTH-1];
            r_pf <= ~^w_f;
        end
    end

    assign F  = r_f;
    assign ZF = r_zf;
    assign CF = r_cf;
    assign OF = r_of;
    assign SF = r_sf;
    assign PF = r_pf;

endmodule

// File: tb/tb_alu32_reg.sv
// tb/tb_alu32_reg.sv - scoreboard bench for alu32_reg: directed vectors plus random ops
module tb_alu32_reg;

    typedef struct {
        logic [31:0] f;
        logic [4:0]  fl;
        string       tag;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  OP = '0;
    logic [31:0] F;
    logic        ZF, CF, OF, SF, PF;

    int   n_err = 0;
    int   n_chk = 0;
    exp_t sb[$];
    vec_t dir[20];

    alu32_reg dut (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .OP(OP),
        .F(F), .ZF(ZF), .CF(CF), .OF(OF), .SF(SF), .PF(PF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Reference model: wide signed arithmetic and bit-at-a-time shifting.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] s;
        longint      sr;
        logic [31:0] f;
        logic        cf, of;
        int          n;
        f = '0; cf = 1'b0; of = 1'b0;
        case (op)
            4'd0: f = a & b;
            4'd1: f = a | b;
            4'd2: f = a ^ b;
            4'd3: f = ~(a | b);
            4'd4: begin
                s  = {1'b0, a} + {1'b0, b};
                f  = s[31:0];
                cf = s[32];
                sr = longint'($signed(a)) + longint'($signed(b));
                of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'd5, 4'd6: begin
                f  = a - b;
                cf = (a < b);
                sr = longint'($signed(a)) - longint'($signed(b));
                of = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                if (op == 4'd6) f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
            4'd7: begin
                if (a >= 32) begin
                    f  = '0;
                    of = (b != 0);
                end else begin
                    f = b;
                    for (int i = 0; i < int'(a); i++) begin
                        if (f[31]) of = 1'b1;
                        f = {f[30:0], 1'b0};
                    end
                end
            end
            default: ;
        endcase
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(f[i]);
        e.f   = f;
        e.fl  = {f == 0, cf, of, f[31], (n % 2) == 0};
        e.tag = "";
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] f_exp, input string tag);
        exp_t e;
        OP = op; A = a; B = b;
        e     = model(op, a, b);
        e.f   = f_exp;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic collect();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_F"}, F, e.f);
            check({e.tag, "_flags"}, {27'd0, ZF, CF, OF, SF, PF}, {27'd0, e.fl});
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] f_exp, input string tag);
        @(negedge clk);
        drive(op, a, b, f_exp, tag);
        @(posedge clk);
        #1;
        collect();
    endtask

    initial begin
        exp_t        m;
        logic [3:0]  op;
        logic [31:0] a, b;

        dir[0]  = '{4'd0, 32'hacd438f4, 32'h1930a333, 32'h08102030};
        dir[1]  = '{4'd0, 32'h00222314, 32'ha9343489, 32'h00202000};
        dir[2]  = '{4'd1, 32'hacd438f4, 32'hd930a333, 32'hfdf4bbf7};
        dir[3]  = '{4'd2, 32'hacd438f4, 32'h1930a333, 32'hb5e49bc7};
        dir[4]  = '{4'd3, 32'hacd438f4, 32'h1930a333, 32'h420b4408};
        dir[5]  = '{4'd4, 32'hacd438f4, 32'h1930a333, 32'hc604dc27};
        dir[6]  = '{4'd4, 32'hf920acdd, 32'h32aabbcc, 32'h2bcb68a9};
        dir[7]  = '{4'd4, 32'h7999aaaa, 32'h79990000, 32'hf332aaaa};
        dir[8]  = '{4'd5, 32'h0cd438f4, 32'h1930a333, 32'hf3a395c1};
        dir[9]  = '{4'd5, 32'haaaabbbb, 32'h2322aaaa, 32'h87881111};
        dir[10] = '{4'd5, 32'h12345678, 32'h12345678, 32'h00000000};
        dir[11] = '{4'd6, 32'hacd438f4, 32'h1930a333, 32'h00000001};
        dir[12] = '{4'd6, 32'h00001111, 32'ha000bbbb, 32'h00000000};
        dir[13] = '{4'd7, 32'h00000009, 32'hacd438f4, 32'ha871e800};
        dir[14] = '{4'd7, 32'h00aaaaaa, 32'h000000aa, 32'h00000000};
        dir[15] = '{4'd7, 32'h00000000, 32'h00000005, 32'h00000005};
        dir[16] = '{4'd7, 32'h00000020, 32'h00000001, 32'h00000000};
        dir[17] = '{4'd7, 32'h0000001f, 32'h00000003, 32'h80000000};
        dir[18] = '{4'd4, 32'hffffffff, 32'h00000001, 32'h00000000};
        dir[19] = '{4'd9, 32'hffffffff, 32'h12345678, 32'h00000000};

        // Ops driven while reset is held must not reach the outputs.
        OP = 4'd4; A = 32'h7fffffff; B = 32'h00000001;
        repeat (3) @(posedge clk);
        #1;
        check("reset_F", F, 32'd0);
        check("reset_flags", {27'd0, ZF, CF, OF, SF, PF}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(4'd4, 32'h7fffffff, 32'h00000001, 32'h80000000, "first_after_reset");
        @(posedge clk);
        #1;
        collect();

        for (int i = 0; i < 20; i++)
            do_op(dir[i].op, dir[i].a, dir[i].b, dir[i].f, $sformatf("dir%0d_op%0d", i, dir[i].op));

        // Asynchronous clear mid-cycle, away from any clock edge.
        do_op(4'd1, 32'hf0f0f0f0, 32'h0f0f0f0f, 32'hffffffff, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_F", F, 32'd0);
        check("async_reset_flags", {27'd0, ZF, CF, OF, SF, PF}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom();
            b  = $urandom();
            if (op == 4'd7) a = $urandom_range(0, 40);
            if (i % 7 == 0) b = a;
            m = model(op, a, b);
            do_op(op, a, b, m.f, $sformatf("rnd%0d_op%0d", i, op));
        end

        if (sb.size() != 0) check("scoreboard_leftover", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
